// File: rtl/md_issue_ctrl.sv
// Issue/stall control for the HI/LO mult/div unit. Issue is combinational in IDLE.
// Stall is raised while an operation is in flight. Completion is tracked by a latency down-counter.
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        instr_valid,
  input  logic        flush,
  output logic        md_start,
  output logic [3:0]  md_op,
  output logic        busy,
  output logic        stall_d,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_MFHI  = 4'd8;
  localparam logic [3:0] OP_MFLO  = 4'd9;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  logic [5:0]         opcode, funct;
  logic [3:0]         op;
  logic               is_md, is_long, is_div, issue;
  logic               unused_instr_bits;

  assign opcode = instr_d[31:26];
  assign funct  = instr_d[5:0];
  assign unused_instr_bits = ^instr_d[25:6];

  always_comb begin
    op = OP_NONE;
    if (opcode == 6'h00) begin
      case (funct)
        6'h10:   op = OP_MFHI;
        6'h11:   op = OP_MTHI;
        6'h12:   op = OP_MFLO;
        6'h13:   op = OP_MTLO;
        6'h18:   op = OP_MULT;
        6'h19:   op = OP_MULTU;
        6'h1A:   op = OP_DIV;
        6'h1B:   op = OP_DIVU;
        default: op = OP_NONE;
      endcase
    end else if (opcode == 6'h1C && funct == 6'h00) begin
      op = OP_MADD;
    end
  end

  assign is_md   = instr_valid && (op != OP_NONE);
  assign is_long = (op >= OP_MULT) && (op <= OP_MADD);
  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
  // Reset holds the command strobe low even though state is already IDLE.
  assign issue   = (state_q == IDLE) && is_md && !flush && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue && is_long) begin
          state_d = RUN;
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      RUN: begin
        // cnt==0 in RUN is unreachable; treat it as expiry so the FSM cannot lock up.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign md_start = issue;
  assign md_op    = issue ? op : OP_NONE;
  assign busy     = (state_q == RUN);
  assign stall_d  = is_md && (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: a cycle-level behavioural model checked every negedge,
// plus literal expectations on latencies and op codes at key points.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        instr_valid;
  logic        flush;
  logic        md_start;
  logic [3:0]  md_op;
  logic        busy;
  logic        stall_d;
  logic        done;

  localparam logic [31:0] I_MULT  = 32'h0043_0018;
  localparam logic [31:0] I_MULTU = 32'h0043_0019;
  localparam logic [31:0] I_DIV   = 32'h0043_001A;
  localparam logic [31:0] I_DIVU  = 32'h0043_001B;
  localparam logic [31:0] I_MADD  = 32'h7043_0000;
  localparam logic [31:0] I_MTHI  = 32'h0040_0011;
  localparam logic [31:0] I_MTLO  = 32'h0040_0013;
  localparam logic [31:0] I_MFHI  = 32'h0000_1010;
  localparam logic [31:0] I_MFLO  = 32'h0000_1012;
  localparam logic [31:0] I_ADDU  = 32'h0043_0821;

  int n_vec  = 0;
  int n_miss = 0;
  bit model_on = 1'b0;

  md_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .instr_valid(instr_valid),
    .flush(flush), .md_start(md_start), .md_op(md_op), .busy(busy),
    .stall_d(stall_d), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Operation code straight from the ISA table.
  function automatic int op_of(input logic [31:0] ins);
    logic [5:0] opc, fn;
    opc = ins[31:26];
    fn  = ins[5:0];
    if (opc == 6'h1C && fn == 6'h00) return 5;
    if (opc != 6'h00) return 0;
    case (fn)
      6'h18: return 1;
      6'h19: return 2;
      6'h1A: return 3;
      6'h1B: return 4;
      6'h11: return 6;
      6'h13: return 7;
      6'h10: return 8;
      6'h12: return 9;
      default: return 0;
    endcase
  endfunction

  // Model: cycles of unit occupancy left, and whether a completion is being reported.
  int remaining = 0;
  bit done_m    = 1'b0;

  function automatic int m_op();
    return instr_valid ? op_of(instr_d) : 0;
  endfunction

  function automatic bit m_start();
    return (remaining == 0) && (m_op() != 0) && !flush && !reset;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      remaining = 0;
      done_m    = 1'b0;
    end else if (remaining > 0) begin
      remaining = remaining - 1;
      done_m    = (remaining == 0);
    end else begin
      done_m = 1'b0;
      if (m_start()) begin
        case (m_op())
          1, 2, 5: remaining = 5;
          3, 4:    remaining = 10;
          default: remaining = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy",     int'(busy),     int'(remaining > 0));
      chk("done",     int'(done),     int'(done_m));
      chk("stall_d",  int'(stall_d),  int'((m_op() != 0) && (remaining > 0)));
      chk("md_start", int'(md_start), int'(m_start()));
      chk("md_op",    int'(md_op),    m_start() ? m_op() : 0);
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
    instr_valid = v;
    instr_d     = ins;
    flush       = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Count consecutive cycles (sampled at posedge+3) while busy holds; ends at posedge+3 of the first idle cycle.
  task automatic count_busy(output int n);
    n = 0;
    #2;
    while (busy && n < 40) begin
      n++;
      @(posedge clk);
      #3;
    end
  endtask

  task automatic count_stall(output int n);
    n = 0;
    #2;
    while (stall_d && n < 40) begin
      n++;
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    model_on = 1'b1;
    repeat (2) next_cycle();
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    next_cycle();

    // MULT: issues immediately, busy 5 cycles, done with busy low on the 6th.
    drive(1'b1, I_MULT, 1'b0);
    #2;
    chk("mult_start", int'(md_start), 1);
    chk("mult_op", int'(md_op), 1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0);
    count_busy(n);
    chk("mult_busy_len", n, 5);
    chk("mult_done", int'(done), 1);
    next_cycle();

    // DIVU followed by MFLO: 10 stall cycles, MFLO issues with done.
    drive(1'b1, I_DIVU, 1'b0);
    next_cycle();
    drive(1'b1, I_MFLO, 1'b0);
    count_stall(n);
    chk("divu_stall_len", n, 10);
    chk("mflo_done", int'(done), 1);
    chk("mflo_start", int'(md_start), 1);
    chk("mflo_op", int'(md_op), 9);
    next_cycle();

    // MTHI is zero-latency, then MADD occupies the unit.
    drive(1'b1, I_MTHI, 1'b0);
    #2;
    chk("mthi_op", int'(md_op), 6);
    next_cycle();
    #2;
    chk("mthi_busy", int'(busy), 0);
    drive(1'b1, I_MADD, 1'b0);
    #1;
    chk("madd_op", int'(md_op), 5);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0);
    count_busy(n);
    chk("madd_busy_len", n, 5);
    next_cycle();

    // Flushed DIV in IDLE does nothing.
    drive(1'b1, I_DIV, 1'b1);
    #2;
    chk("flush_start", int'(md_start), 0);
    next_cycle();
    #2;
    chk("flush_busy", int'(busy), 0);

    // Flush during RUN does not abort the in-flight MULTU.
    drive(1'b1, I_MULTU, 1'b0);
    next_cycle();
    drive(1'b1, I_MULT, 1'b1);
    count_busy(n);
    chk("flush_run_len", n, 5);
    chk("flush_run_done", int'(done), 1);
    drive(1'b0, 32'h0, 1'b0);
    next_cycle();

    // Non-md and invalid instructions, in IDLE then during a DIV.
    drive(1'b1, I_ADDU, 1'b0);
    #2;
    chk("addu_idle_start", int'(md_start), 0);
    next_cycle();
    drive(1'b0, I_MULT, 1'b0);
    #2;
    chk("inv_idle_start", int'(md_start), 0);
    next_cycle();
    drive(1'b1, I_DIV, 1'b0);
    next_cycle();
    drive(1'b1, I_ADDU, 1'b0);
    #2;
    chk("addu_run_stall", int'(stall_d), 0);
    next_cycle();
    drive(1'b0, I_MULT, 1'b0);
    #2;
    chk("inv_run_stall", int'(stall_d), 0);
    chk("inv_run_op", int'(md_op), 0);
    next_cycle();
    drive(1'b1, I_MTLO, 1'b0);
    #2;
    chk("mtlo_run_stall", int'(stall_d), 1);
    next_cycle();

    // Reset mid-DIV (three cycles in), then an immediate MULT issue.
    drive(1'b1, I_DIV, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(1'b1, I_MFHI, 1'b0);
    #2;
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_done", int'(done), 0);
    chk("post_rst_stall", int'(stall_d), 0);
    chk("post_rst_mfhi", int'(md_op), 8);
    next_cycle();
    drive(1'b1, I_MULT, 1'b0);
    #2;
    chk("post_rst_mult", int'(md_start), 1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0);
    count_busy(n);
    chk("post_rst_len", n, 5);
    repeat (3) next_cycle();

    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
